ksa_multiword_adder: RTL and testbench

Multi-cycle sequencer that adds two WORDS×CHUNK-bit operands by running one CHUNK-bit Kogge-Stone slice once per cycle, least significant chunk first, and chaining the carry through a register. It sits between a valid/ready producer and consumer wherever a full-width single-cycle prefix adder is too large or too slow. It trades latency (WORDS cycles) for area (one CHUNK-wide prefix tree).

---
 rtl/ksa_multiword_pkg.sv | 18 +
 rtl/ksa_chunk_adder.sv | 29 ++
 rtl/ksa_prefix_adder.sv | 43 ++++
 rtl/ksa_multiword_adder.sv | 119 +++++++++++
 tb/tb_ksa_multiword_adder.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ksa_multiword_pkg.sv
// Purpose: shared types and helpers for the multi-word Kogge-Stone adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package ksa_multiword_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the chunk index counter. It is never narrower than one bit,
  // so WORDS=1 still gets a legal vector.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/ksa_chunk_adder.sv
// Purpose: CHUNK-bit slice adder with carry-in, built on a CHUNK+1-bit Kogge-Stone core.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b (CHUNK-bit slice operands), cin (carry in), s (CHUNK-bit slice sum), cout (slice carry).
module ksa_chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] ext_s;

  // The core has no carry input. Placing cin at bit 0 of both operands
  // gives cin+cin, so result bit 0 is always 0 and cin enters bit 1 as a
  // carry. The upper CHUNK bits are then a + b + cin.
  ksa_prefix_adder #(.N(CHUNK + 1)) u_core (
    .a    ({a, cin}),
    .b    ({b, cin}),
    .s    (ext_s),
    .cout (cout)
  );

  assign s = ext_s[CHUNK:1];

endmodule

// File: rtl/ksa_prefix_adder.sv
// Purpose: parameterised N-bit Kogge-Stone adder with no carry input.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b (N-bit addends), s (N-bit sum), cout (carry out of bit N-1).
module ksa_prefix_adder #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] p;   // bitwise propagate, kept for the final sum XOR
  logic [N-1:0] g;   // group generate, refined at each prefix level
  logic [N-1:0] pp;  // group propagate, refined at each prefix level
  logic [N-1:0] gn;
  logic [N-1:0] pn;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    pp = p;
    gn = g;
    pn = pp;
    // log2(N) levels. Level d combines each bit with the group that
    // ends d positions below it.
    for (int d = 1; d < N; d = d * 2) begin
      gn = g;
      pn = pp;
      for (int i = d; i < N; i++) begin
        gn[i] = g[i] | (pp[i] & g[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      g  = gn;
      pp = pn;
    end
    // Carry into bit i is the group generate of bits i-1..0.
    s    = p ^ (g << 1);
    cout = g[N-1];
  end

endmodule

// File: rtl/ksa_multiword_adder.sv
// Purpose: adds two CHUNK*WORDS-bit operands one CHUNK slice per cycle, LSB chunk first.
// Latency: out_valid rises WORDS cycles after the accept edge; one op per WORDS+2 cycles at best.
// Backpressure: result is held in DONE until out_ready; in_ready is low while busy.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in1/in2 operand handshake;
//        out_valid/out_ready/sum/cout result handshake.
// Optional: define KSA_MULTIWORD_SUB_EN to add an op_sub input (1 = A - B, cout = no borrow).
module ksa_multiword_adder
  import ksa_multiword_pkg::*;
#(
  parameter int CHUNK = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHUNK*WORDS-1:0] in1,
  input  logic [CHUNK*WORDS-1:0] in2,
`ifdef KSA_MULTIWORD_SUB_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHUNK*WORDS-1:0] sum,
  output logic                   cout
);

  localparam int W  = CHUNK * WORDS;
  localparam int KW = idx_width(WORDS);
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     sum_r;
  logic             carry_r;
  logic [KW-1:0]    k;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic [W-1:0]     b_load;
  logic             c_init;
  logic             accept;
  logic             last;

`ifdef KSA_MULTIWORD_SUB_EN
  // A - B = A + ~B + 1: store B inverted and seed the carry chain with 1.
  assign b_load = op_sub ? ~in2 : in2;
  assign c_init = op_sub;
`else
  assign b_load = in2;
  assign c_init = 1'b0;
`endif

  assign slice_a = opa[k*CHUNK +: CHUNK];
  assign slice_b = opb[k*CHUNK +: CHUNK];
  assign last    = (k == K_LAST);
  assign accept  = (state == IDLE) && in_valid;

  ksa_chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_r),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opa     <= '0;
      opb     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      k       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opa     <= in1;
        opb     <= b_load;
        carry_r <= c_init;
        k       <= '0;
        sum_r   <= '0;
      end else if (state == RUN) begin
        sum_r[k*CHUNK +: CHUNK] <= slice_s;
        carry_r                 <= slice_c;
        // Park the index at 0 after the last chunk so it never points
        // past the operand while idle.
        k                       <= last ? '0 : k + 1'b1;
      end
    end
  end

  assign sum  = sum_r;
  assign cout = carry_r;

endmodule

// File: tb/tb_ksa_multiword_adder.sv
module tb_ksa_multiword_adder;

  localparam int CH = 16;
  localparam int WD = 4;
  localparam int W  = CH * WD;
  localparam int W1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic to_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired without the expected DUT event", nm);
  endtask

  // Reference: plain unsigned arithmetic on a W+1-bit result.
  function automatic logic [W:0] ref_main(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b};
    end
    return r;
  endfunction

  function automatic logic [W1:0] ref_w1(input logic [W1-1:0] a, input logic [W1-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // ---------------- main DUT: CHUNK=16, WORDS=4 ----------------
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         rand_rdy;
  logic         hold_rdy;
  logic         rnd_rdy;
`ifdef KSA_MULTIWORD_SUB_EN
  logic         op_sub_r;
`endif

  assign out_ready = rand_rdy ? rnd_rdy : hold_rdy;

  ksa_multiword_adder #(.CHUNK(CH), .WORDS(WD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
`ifdef KSA_MULTIWORD_SUB_EN
    .op_sub    (op_sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  logic [W:0] exp_q[$];
  time        lat_q[$];

  always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  // Issue one operation; called at posedge+1, returns at posedge+1 after accept.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      to_fail("op_accept_wait");
      return;
    end
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
`ifdef KSA_MULTIWORD_SUB_EN
    op_sub_r = sub;
`endif
    exp_q.push_back(ref_main(a, b, sub));
    @(posedge clk);
    lat_q.push_back($time);
    #1;
    // Operands changing after the accept edge must not matter.
    in_valid = 1'b0;
    in1      = {$urandom, $urandom};
    in2      = {$urandom, $urandom};
`ifdef KSA_MULTIWORD_SUB_EN
    op_sub_r = 1'($urandom);
`endif
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) to_fail(nm);
  endtask

  // Monitor: latency on out_valid rise, result on each handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) to_fail("latency_unexpected_valid");
        else chk("latency", 128'($time - lat_q.pop_front()), 128'(WD * 10 + 5));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          to_fail("result_unexpected");
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          chk("sum", 128'(sum), 128'(e[W-1:0]));
          chk("cout", 128'(cout), 128'(e[W]));
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- second DUT: CHUNK=8, WORDS=1 ----------------
  logic          rst1_n;
  logic          v_in_valid;
  logic          v_in_ready;
  logic [W1-1:0] v_in1;
  logic [W1-1:0] v_in2;
  logic          v_out_valid;
  logic          v_out_ready;
  logic [W1-1:0] v_sum;
  logic          v_cout;
  logic          w1_done = 1'b0;

  always @(posedge clk) v_out_ready <= ($urandom_range(0, 2) != 0);

  ksa_multiword_adder #(.CHUNK(W1), .WORDS(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .in_valid  (v_in_valid),
    .in_ready  (v_in_ready),
    .in1       (v_in1),
    .in2       (v_in2),
`ifdef KSA_MULTIWORD_SUB_EN
    .op_sub    (1'b0),
`endif
    .out_valid (v_out_valid),
    .out_ready (v_out_ready),
    .sum       (v_sum),
    .cout      (v_cout)
  );

  logic [W1:0] exp1_q[$];
  time         lat1_q[$];

  task automatic op1(input logic [W1-1:0] a, input logic [W1-1:0] b);
    int n = 0;
    while (!v_in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!v_in_ready) begin
      to_fail("w1_accept_wait");
      return;
    end
    v_in_valid = 1'b1;
    v_in1      = a;
    v_in2      = b;
    exp1_q.push_back(ref_w1(a, b));
    @(posedge clk);
    lat1_q.push_back($time);
    #1;
    v_in_valid = 1'b0;
    v_in1      = 8'($urandom);
    v_in2      = 8'($urandom);
  endtask

  logic prev_ov1 = 1'b0;
  always @(negedge clk) begin
    if (!rst1_n) begin
      prev_ov1 = 1'b0;
    end else begin
      if (v_out_valid && !prev_ov1) begin
        if (lat1_q.size() == 0) to_fail("w1_latency_unexpected_valid");
        else chk("w1_latency", 128'($time - lat1_q.pop_front()), 128'(15));
      end
      if (v_out_valid && v_out_ready) begin
        if (exp1_q.size() == 0) begin
          to_fail("w1_result_unexpected");
        end else begin
          logic [W1:0] e;
          e = exp1_q.pop_front();
          chk("w1_sum", 128'(v_sum), 128'(e[W1-1:0]));
          chk("w1_cout", 128'(v_cout), 128'(e[W1]));
        end
      end
      prev_ov1 = v_out_valid;
    end
  end

  initial begin
    rst1_n     = 1'b0;
    v_in_valid = 1'b0;
    v_in1      = '0;
    v_in2      = '0;
    repeat (3) @(posedge clk);
    #1;
    rst1_n = 1'b1;
    op1(8'hFF, 8'h01);
    for (int i = 0; i < 10000; i++) begin
      logic [W1-1:0] a;
      logic [W1-1:0] b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 16 == 0) a = 8'hFF;
      op1(a, b);
    end
    for (int n = 0; n < 200 && exp1_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("w1_drain", 128'(exp1_q.size()), 128'(0));
    w1_done = 1'b1;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W:0] e;
    int         n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in1      = '0;
    in2      = '0;
    rand_rdy = 1'b0;
    hold_rdy = 1'b1;
`ifdef KSA_MULTIWORD_SUB_EN
    op_sub_r = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_sum", 128'(sum), 128'(0));
    chk("rst_cout", 128'(cout), 128'(0));
    rst_n = 1'b1;

    op(64'd1, 64'd2, 1'b0);
    drain("drain_small");
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    drain("drain_ripple");

    // Back-pressure: hold the result, poke in_valid, then release.
    hold_rdy = 1'b0;
    op(64'h8000_0000_FFFF_0001, 64'h8000_0001_0001_FFFF, 1'b0);
    e = ref_main(64'h8000_0000_FFFF_0001, 64'h8000_0001_0001_FFFF, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      to_fail("bp_wait_valid");
    end else begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        in1      = {$urandom, $urandom};
        in2      = {$urandom, $urandom};
        @(posedge clk);
        #1;
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_sum", 128'(sum), 128'(e[W-1:0]));
        chk("bp_cout", 128'(cout), 128'(e[W]));
      end
    end
    in_valid = 1'b0;
    hold_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    chk("bp_release_out_valid", 128'(out_valid), 128'(0));
    drain("drain_bp");

    // Reset while the third chunk is in flight.
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_sum", 128'(sum), 128'(0));
    chk("midrst_cout", 128'(cout), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op(64'h1234, 64'h4321, 1'b0);
    drain("drain_after_rst");

`ifdef KSA_MULTIWORD_SUB_EN
    op(64'd5, 64'd7, 1'b1);
    op(64'd7, 64'd5, 1'b1);
    drain("drain_sub");
`endif

    // Random back-to-back traffic with random consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = '0;
        2: b = ~a;
        default: ;
      endcase
      s = 1'b0;
`ifdef KSA_MULTIWORD_SUB_EN
      s = 1'($urandom);
`endif
      op(a, b, s);
    end
    drain("drain_random");
    rand_rdy = 1'b0;

    n = 0;
    while (!w1_done && n < 80000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!w1_done) to_fail("w1_finish_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
